// File: rtl/regbank_pkg.sv
// Shared parameters and FSM state type for the register-bank write arbiter.
// Holds the 8x4 bank defaults so the arbiter and the bank agree on geometry.
package regbank_pkg;

  localparam int REGBANK_ADDR_W = 3;
  localparam int REGBANK_DATA_W = 4;
  localparam int REGBANK_NREGS  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // A single-register bank still needs a 1-bit counter to hold its terminal count.
  function automatic int clrCntWidth(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational from requests; 0-cycle latency.
// Grants only when enabled; the pointer moves on a transfer only, so a stalled requester keeps its turn.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // Set when requester 1 won most recently; reset value lets requester 0 win the first conflict.
  logic lastGnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = lastGnt1;
        gnt1 = !lastGnt1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt1 <= 1'b1;
    end else if (gnt0) begin
      lastGnt1 <= 1'b0;
    end else if (gnt1) begin
      lastGnt1 <= 1'b1;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates two writers onto one register-bank write port and runs a bank-clear sequence.
// Write appears 1 cycle after the grant edge; requests stall (no gnt) while clearing or when clr_start is high.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int ADDR_W = REGBANK_ADDR_W,
  parameter int DATA_W = REGBANK_DATA_W,
  parameter int NREGS  = REGBANK_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] dat0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dat1,
  output logic              gnt1,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] addrW,
  output logic [DATA_W-1:0] datW,
  output logic              RegWrite
);

  localparam int CNT_W = clrCntWidth(NREGS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NREGS - 1);

  state_t           state;
  logic [CNT_W-1:0] clrCnt;
  logic [CNT_W-1:0] clrCntNext;
  logic             arbEn;

  // clr_start outranks both requesters, and reset blocks grants outright.
  assign arbEn      = (state == IDLE) && !clr_start && !rst;
  assign clrCntNext = clrCnt + CNT_W'(1);

  rr_arb2 uArb (
    .clk  (clk),
    .rst  (rst),
    .en   (arbEn),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clrCnt   <= '0;
      RegWrite <= 1'b0;
      addrW    <= '0;
      datW     <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clrCnt   <= '0;
            RegWrite <= 1'b1;
            addrW    <= '0;
            datW     <= '0;
            clr_busy <= 1'b1;
          end else if (gnt0) begin
            RegWrite <= 1'b1;
            addrW    <= addr0;
            datW     <= dat0;
          end else if (gnt1) begin
            RegWrite <= 1'b1;
            addrW    <= addr1;
            datW     <= dat1;
          end else begin
            RegWrite <= 1'b0;
          end
        end
        CLEAR: begin
          // clrCnt mirrors the address on the port this cycle; stop on the last one.
          if (clrCnt == LAST_CNT) begin
            state    <= IDLE;
            clrCnt   <= '0;
            RegWrite <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clrCnt   <= clrCntNext;
            addrW    <= ADDR_W'(clrCntNext);
            RegWrite <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed and random bench for regbank_write_arbiter against a queue-based reference model.
module tb_regbank_write_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int NREGS  = 8;

  logic              clk;
  logic              rst;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] dat0, dat1;
  logic              gnt0, gnt1;
  logic              clr_start, clr_busy, clr_done;
  logic [ADDR_W-1:0] addrW;
  logic [DATA_W-1:0] datW;
  logic              RegWrite;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic              expRW, expBusy, expDone, modelValid;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expDat;
  int                lastWin;
  logic [ADDR_W-1:0] clrQ[$];
  logic [DATA_W-1:0] refBank[NREGS];
  logic [DATA_W-1:0] dutBank[NREGS];

  regbank_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .addr0     (addr0),
    .dat0      (dat0),
    .gnt0      (gnt0),
    .req1      (req1),
    .addr1     (addr1),
    .dat1      (dat1),
    .gnt1      (gnt1),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .addrW     (addrW),
    .datW      (datW),
    .RegWrite  (RegWrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The existing 8x4 bank, fed straight from the write port.
  always @(posedge clk) begin
    if (RegWrite) dutBank[addrW] <= datW;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare at the falling edge, then advance the model across the next rising edge.
  task automatic step();
    int win;
    @(negedge clk);
    win = -1;
    if (!rst && !expBusy && !clr_start) begin
      if (req0 && req1) win = (lastWin == 1) ? 0 : 1;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
    end
    check("gnt0", 32'(gnt0), 32'(win == 0));
    check("gnt1", 32'(gnt1), 32'(win == 1));
    if (modelValid) begin
      check("RegWrite", 32'(RegWrite), 32'(expRW));
      check("addrW",    32'(addrW),    32'(expAddr));
      check("datW",     32'(datW),     32'(expDat));
      check("clr_busy", 32'(clr_busy), 32'(expBusy));
      check("clr_done", 32'(clr_done), 32'(expDone));
    end
    expDone = 1'b0;
    if (rst) begin
      modelValid = 1'b1;
      expRW = 1'b0; expAddr = '0; expDat = '0; expBusy = 1'b0;
      clrQ.delete();
      lastWin = 1;
    end else if (expBusy) begin
      if (clrQ.size() > 0) begin
        expAddr = clrQ.pop_front();
        expRW   = 1'b1;
      end else begin
        expBusy = 1'b0; expRW = 1'b0; expDone = 1'b1;
      end
    end else if (clr_start) begin
      expBusy = 1'b1; expRW = 1'b1; expAddr = '0; expDat = '0;
      for (int i = 1; i < NREGS; i++) clrQ.push_back(ADDR_W'(i));
    end else if (win >= 0) begin
      expRW   = 1'b1;
      expAddr = (win == 0) ? addr0 : addr1;
      expDat  = (win == 0) ? dat0 : dat1;
      lastWin = win;
    end else begin
      expRW = 1'b0;
    end
    if (expRW) refBank[expAddr] = expDat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; clr_start = 1'b0;
    addr0 = '0; addr1 = '0; dat0 = '0; dat1 = '0;
    expRW = 1'b0; expBusy = 1'b0; expDone = 1'b0; modelValid = 1'b0;
    expAddr = '0; expDat = '0; lastWin = 1;
    for (int i = 0; i < NREGS; i++) begin
      refBank[i] = '1;
      dutBank[i] = '1;
    end

    // Reset, then a lone requester
    step(); step();
    rst = 1'b0; req0 = 1'b1; addr0 = 3'd6; dat0 = 4'd5;
    #1 check("rst_first_gnt0", 32'(gnt0), 32'd1);
    step();
    req0 = 1'b0;
    check("rst_wr_en", 32'(RegWrite), 32'd1);
    check("rst_wr_addr", 32'(addrW), 32'd6);
    check("rst_wr_dat", 32'(datW), 32'd5);
    step();

    // Conflict from a fresh pointer: 0,1,0,1
    rst = 1'b1; step(); step(); rst = 1'b0;
    req0 = 1'b1; addr0 = 3'd1; dat0 = 4'd11;
    req1 = 1'b1; addr1 = 3'd2; dat1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("conf_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("conf_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      if (i > 0) begin
        check("conf_wr_en", 32'(RegWrite), 32'd1);
        check("conf_wr_addr", 32'(addrW), ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    check("conf_last_addr", 32'(addrW), 32'd2);
    check("conf_last_dat", 32'(datW), 32'd3);
    step();
    check("bank_a1", 32'(dutBank[1]), 32'd11);
    check("bank_b6", 32'(dutBank[6]), 32'd5);

    // Clear wins over a pending request, which then waits
    req1 = 1'b1; addr1 = 3'd5; dat1 = 4'd9; clr_start = 1'b1;
    #1 check("clr_blocks_gnt1", 32'(gnt1), 32'd0);
    step();
    clr_start = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      check("clr_busy_on", 32'(clr_busy), 32'd1);
      check("clr_addr", 32'(addrW), 32'(i));
      check("clr_dat", 32'(datW), 32'd0);
      check("clr_no_gnt1", 32'(gnt1), 32'd0);
      step();
    end
    check("clr_done_pulse", 32'(clr_done), 32'd1);
    check("clr_busy_off", 32'(clr_busy), 32'd0);
    check("clr_then_gnt1", 32'(gnt1), 32'd1);
    check("bank_a1_clr", 32'(dutBank[1]), 32'd0);
    check("bank_b6_clr", 32'(dutBank[6]), 32'd0);
    step();
    req1 = 1'b0;
    check("clr_done_once", 32'(clr_done), 32'd0);
    check("pend_addr", 32'(addrW), 32'd5);
    check("pend_dat", 32'(datW), 32'd9);
    step();

    // Reset during the 4th clear cycle
    clr_start = 1'b1; step(); clr_start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    check("mid_addr", 32'(addrW), 32'd3);
    step();
    rst = 1'b0;
    check("mid_busy", 32'(clr_busy), 32'd0);
    check("mid_wr", 32'(RegWrite), 32'd0);
    check("mid_done", 32'(clr_done), 32'd0);
    step();
    check("mid_done_later", 32'(clr_done), 32'd0);
    step();

    // clr_start held: one sequence, then another straight from IDLE
    clr_start = 1'b1; step();
    for (int i = 0; i < NREGS; i++) step();
    check("hold_idle_gap", 32'(clr_busy), 32'd0);
    check("hold_done", 32'(clr_done), 32'd1);
    step();
    check("hold_restart", 32'(clr_busy), 32'd1);
    check("hold_restart_addr", 32'(addrW), 32'd0);
    clr_start = 1'b0;
    for (int i = 0; i < NREGS + 1; i++) step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      clr_start = ($urandom_range(0, 14) == 0);
      req0      = 1'($urandom_range(0, 1));
      req1      = 1'($urandom_range(0, 1));
      addr0     = ADDR_W'($urandom);
      addr1     = ADDR_W'($urandom);
      dat0      = DATA_W'($urandom);
      dat1      = DATA_W'($urandom);
      step();
    end
    rst = 1'b0; clr_start = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    for (int i = 0; i < NREGS; i++) check("bank_final", 32'(dutBank[i]), 32'(refBank[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register-bank address width.
REQ-002 SHALL have parameter DATA_W, default 4, register-bank data width.
REQ-003 SHALL have parameter NREGS, default 8, number of bank registers cleared by the clear sequence.
REQ-004 SHALL have ports, one clock and synchronous active-high reset:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 write request
- addr0  in  ADDR_W  requester 0 write address
- dat0  in  DATA_W  requester 0 write data
- gnt0  out  1  requester 0 accepted this cycle
- req1, addr1, dat1, gnt1  (as requester 0, for requester 1)
- clr_start  in  1  start bank-clear sequence
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse, clear finished
- addrW  out  ADDR_W  bank write address
- datW  out  DATA_W  bank write data
- RegWrite  out  1  bank write enable

Function
REQ-005 SHALL implement an FSM with states IDLE and CLEAR.
REQ-006 SHALL transfer a request on a rising edge where req_i and gnt_i are both high; gnt_i SHALL be combinational from req_i, state and the priority pointer.
REQ-007 SHALL assert at most one gnt per cycle, and only in IDLE with clr_start low.
REQ-008 SHALL, when exactly one requester is requesting in IDLE, grant it.
REQ-009 SHALL, when both request, grant the requester not granted most recently; the pointer SHALL update only on a transfer.
REQ-010 SHALL, for a transfer at edge k, drive RegWrite=1, addrW=addr_i and datW=dat_i (values sampled at edge k) for exactly the cycle after edge k; latency 1 cycle.
REQ-011 SHALL support back-to-back transfers: one write per cycle while requests persist.
REQ-012 SHALL drive RegWrite=0 in any cycle not following a transfer or clear step; addrW and datW SHALL hold their last values.
REQ-013 SHALL, when clr_start is high in IDLE, enter CLEAR at the next edge; clr_start SHALL take priority over both requests, with no gnt that cycle.
REQ-014 SHALL, in CLEAR, drive RegWrite=1, datW=0 and addrW=0,1,...,NREGS-1 in consecutive cycles, with clr_busy=1 during all NREGS cycles.
REQ-015 SHALL return to IDLE after address NREGS-1 is written and pulse clr_done for the first IDLE cycle.
REQ-016 SHALL ignore clr_start while in CLEAR and hold gnt0=gnt1=0; pending requests SHALL wait without loss.
REQ-017 SHALL size the clear counter ceil(log2(NREGS)) bits and end on its terminal count, not on wrap-around.

Reset
REQ-018 SHALL, when rst is high at a rising edge, enter IDLE and set RegWrite=0, addrW=0, datW=0, clr_busy=0, clr_done=0, clear counter=0, and the pointer so requester 0 wins the first conflict.
REQ-019 SHALL, on reset during CLEAR, abort the sequence with no clr_done pulse; the bank SHALL be left partially cleared.
REQ-020 SHALL hold gnt0=gnt1=0 while rst is high.

Structure
REQ-021 SHALL take ADDR_W, DATA_W and NREGS defaults and the FSM state type from shared package regbank_pkg.
REQ-022 SHALL place grant logic and pointer in one sub-module, rr_arb2; the FSM, counter and output registers SHALL stay in the top.
REQ-023 SHALL connect addrW/datW/RegWrite directly to the existing 8x4 register-bank write port without glue logic.

Verification
REQ-024 Reset: rst=1 two cycles, then req0=1 addr0=6 dat0=5 -> gnt0=1 in the first cycle after reset; next cycle RegWrite=1, addrW=6, datW=5.
REQ-025 Conflict: req0 and req1 held 4 cycles (addr0=1 dat0=11, addr1=2 dat1=3) -> grants 0,1,0,1; RegWrite high on 4 consecutive cycles, with matching addr/dat.
REQ-026 Clear: clr_start=1 one cycle with req1=1 -> gnt1=0; clr_busy high 8 cycles; addrW 0..7, datW=0; clr_done pulses once; then gnt1=1.
REQ-027 Reset mid-clear: rst=1 at the 4th CLEAR cycle -> next cycle clr_busy=0, RegWrite=0, no clr_done pulse.
REQ-028 clr_start held high through CLEAR -> only one 8-cycle sequence, then a second begins immediately from IDLE.
REQ-029 End-to-end with the bank: write addr 6 = 5 and addr 1 = 11, read ports addrA=1, addrB=6 -> 11 and 5; after a clear, both read 0.
